// File: rtl/bz_router_pkg.sv
// Shared router definitions: flit layout, worm packet geometry and the
// arbiter state encoding used by the worm arbiters.
package bz_router_pkg;

  localparam int NFLIT      = 11;
  localparam int TAIL_BIT   = 0;
  localparam int NDATAFLITS = 3;

  typedef struct packed {
    logic [9:0] payload;
    logic       tail;
  } flit_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from last+1, wrapping modulo N (N need not be a power of 2).
module rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!found && req[IW'(pos)]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/bz_worm_arbiter.sv
// Worm-locking round-robin arbiter: multiplexes NPORTS show-ahead router FIFOs
// onto one deserializer input, holding each grant from header to final tail.
module bz_worm_arbiter #(
  parameter int NPORTS     = 4,
  parameter int NFLIT      = bz_router_pkg::NFLIT,
  parameter int NDATAFLITS = bz_router_pkg::NDATAFLITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS-1:0]         port_enable,
  input  logic [NPORTS-1:0]         fifo_isempty,
  input  logic [NPORTS*NFLIT-1:0]   fifo_data,
  output logic [NPORTS-1:0]         fifo_rdreq,
  output logic                      out_isempty,
  output logic [NFLIT-1:0]          out_data,
  input  logic                      out_rdreq,
  output logic                      grant_valid,
  output logic [$clog2(NPORTS)-1:0] grant_idx
);

  import bz_router_pkg::*;

  localparam int GW = $clog2(NPORTS);
  localparam int CW = $clog2(NDATAFLITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(NDATAFLITS);

  arb_state_t        state_reg;
  logic [GW-1:0]     grant_reg;
  logic [GW-1:0]     last_reg;
  logic [CW-1:0]     cnt_reg;

  logic [NPORTS-1:0] req;
  logic              found;
  logic [GW-1:0]     pick;
  logic [NFLIT-1:0]  head [NPORTS];
  logic              locked;
  logic              xfer;
  logic              tail;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      assign head[gi]       = fifo_data[gi*NFLIT +: NFLIT];
      assign req[gi]        = !fifo_isempty[gi] && port_enable[gi];
      assign fifo_rdreq[gi] = locked && (grant_reg == GW'(gi)) &&
                              out_rdreq && !fifo_isempty[gi];
    end
  endgenerate

  rr_select #(
    .N(NPORTS)
  ) u_pick (
    .req  (req),
    .last (last_reg),
    .found(found),
    .idx  (pick)
  );

  // The locked port's FIFO is passed straight through so a bubble upstream
  // appears to the deserializer as plain emptiness.
  assign locked      = (state_reg == ARB_LOCKED);
  assign out_isempty = locked ? fifo_isempty[grant_reg] : 1'b1;
  assign out_data    = locked ? head[grant_reg] : '0;
  assign xfer        = out_rdreq && !out_isempty;
  assign tail        = head[grant_reg][TAIL_BIT];
  assign grant_valid = locked;
  assign grant_idx   = grant_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ARB_IDLE;
      cnt_reg   <= '0;
      grant_reg <= '0;
      last_reg  <= GW'(NPORTS - 1);
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (found) begin
            state_reg <= ARB_LOCKED;
            grant_reg <= pick;
            cnt_reg   <= '0;
          end
        end
        ARB_LOCKED: begin
          // Tail is only meaningful on the last data flit of a packet.
          if (xfer) begin
            if (cnt_reg != LAST_DATA) begin
              cnt_reg <= cnt_reg + 1'b1;
            end else if (tail) begin
              state_reg <= ARB_IDLE;
              last_reg  <= grant_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= CW'(1);
            end
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule
